// File: rtl/gen_intf_chan_merge_pkg.sv
// Shared types and helpers for the multi-channel stream merger.
// Buffer kinds, channel tag and width helper.
package gen_intf_chan_pkg;

  localparam int MAX_CH = 16;

  typedef enum logic {
    BUF_SKID,
    BUF_FIFO
  } buf_mode_e;

  typedef struct packed {
    logic [3:0] ch;
  } tag_t;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gen_intf_chan_merge_if.sv
// Handshake bundle for the merger: N input channels and one tagged output.
// The master side drives inputs; the slave side is the merger.
interface gen_intf_chan_merge_if #(
  parameter int N_CH = 4,
  parameter int W    = 8,
  parameter int CHW  = 2
);
  logic [N_CH-1:0]   in_valid;
  logic [N_CH-1:0]   in_ready;
  logic [N_CH*W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic [CHW-1:0]    out_ch;
  logic [15:0]       drop_cnt;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data,
    input  out_ch, drop_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data,
    output out_ch, drop_cnt
  );
endinterface

// File: rtl/gen_intf_chan_merge_buf.sv
// Per-channel buffer: DEPTH-entry FIFO or 2-entry skid.
// Full refuses push even on a same-cycle pop; no empty bypass.
module gen_chan_buf
  import gen_intf_chan_pkg::*;
#(
  parameter int        W     = 8,
  parameter int        DEPTH = 4,
  parameter buf_mode_e MODE  = BUF_FIFO
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int ND = (MODE == BUF_FIFO) ? DEPTH : 2;
  localparam int AW = $clog2(ND);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [ND];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == CW'(ND));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/gen_intf_chan_merge.sv
// Round-robin merge of N buffered channels into one registered,
// channel-tagged output stream with a saturating refused-push counter.
module gen_intf_chan_merge
  import gen_intf_chan_pkg::*;
#(
  parameter int              N_CH    = 4,
  parameter int              W       = 8,
  parameter int              DEPTH   = 4,
  parameter logic [MAX_CH-1:0] CH_MODE = 16'h0005
) (
  input logic                  clk,
  input logic                  rst_n,
  gen_intf_chan_merge_if.slave bus
);
  localparam int CHW = clog2_min1(N_CH);

  if (N_CH > MAX_CH || N_CH < 1) begin : g_bad_nch
    $error("gen_intf_chan_merge: N_CH out of range");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("gen_intf_chan_merge: DEPTH must be a power of 2 >= 2");
  end

  logic [N_CH-1:0] full;
  logic [N_CH-1:0] empty;
  logic [N_CH-1:0] pop;
  logic [W-1:0]    rdata [N_CH];
  logic [CHW-1:0]  rr;
  logic [CHW-1:0]  win;
  logic            found;
  logic            ld;
  int              j;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    if (CH_MODE[i]) begin : g_fifo
      gen_chan_buf #(
        .W(W), .DEPTH(DEPTH), .MODE(BUF_FIFO)
      ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.in_valid[i]),
        .pop   (pop[i]),
        .wdata (bus.in_data[i*W +: W]),
        .rdata (rdata[i]),
        .full  (full[i]),
        .empty (empty[i])
      );
    end else begin : g_skid
      gen_chan_buf #(
        .W(W), .DEPTH(DEPTH), .MODE(BUF_SKID)
      ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.in_valid[i]),
        .pop   (pop[i]),
        .wdata (bus.in_data[i*W +: W]),
        .rdata (rdata[i]),
        .full  (full[i]),
        .empty (empty[i])
      );
    end
  end

  assign bus.in_ready = ~full;

  // Scan from the channel after the last winner, wrapping once.
  always_comb begin
    win   = rr;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= N_CH; k++) begin
      j = (int'(rr) + k) % N_CH;
      if (!found && !empty[j]) begin
        win   = CHW'(j);
        found = 1'b1;
      end
    end
  end

  assign ld = (~bus.out_valid | bus.out_ready) & found;

  always_comb begin
    pop = '0;
    if (ld) pop[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
      rr            <= CHW'(N_CH - 1);
    end else if (ld) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= rdata[win];
      bus.out_ch    <= win;
      rr            <= win;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.drop_cnt <= '0;
    end else if (|(bus.in_valid & full) && bus.drop_cnt != 16'hFFFF) begin
      bus.drop_cnt <= bus.drop_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_gen_intf_chan_merge.sv
// Bench for gen_intf_chan_merge: directed scenarios plus random traffic
// checked every cycle against a queue-based reference model.
module tb_gen_intf_chan_merge;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam logic [3:0] MODE = 4'b0101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  gen_intf_chan_merge_if #(.N_CH(N), .W(W), .CHW(2)) bus ();

  gen_intf_chan_merge #(
    .N_CH(N), .W(W), .DEPTH(4), .CH_MODE(16'h0005)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  mq [N][$];
  int          m_rr;
  logic        m_ov;
  logic [7:0]  m_od;
  int          m_och;
  int          m_drop;

  function automatic int cap(input int i);
    return MODE[i] ? 4 : 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mq[i].delete();
    m_rr = N - 1;
    m_ov = 1'b0;
    m_od = '0;
    m_och = 0;
    m_drop = 0;
  endtask

  task automatic tick();
    bit acc [N];
    bit rej;
    bit anyq;
    int w;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      rej = 0;
      anyq = 0;
      for (int i = 0; i < N; i++) begin
        acc[i] = bus.in_valid[i] && (mq[i].size() < cap(i));
        if (bus.in_valid[i] && !acc[i]) rej = 1;
        if (mq[i].size() > 0) anyq = 1;
      end
      if ((!m_ov || bus.out_ready) && anyq) begin
        w = -1;
        for (int k = 1; k <= N && w < 0; k++)
          if (mq[(m_rr + k) % N].size() > 0) w = (m_rr + k) % N;
        m_od = mq[w].pop_front();
        m_och = w;
        m_rr = w;
        m_ov = 1'b1;
      end else if (bus.out_ready) begin
        m_ov = 1'b0;
      end
      for (int i = 0; i < N; i++)
        if (acc[i]) mq[i].push_back(bus.in_data[i*W +: W]);
      if (rej && m_drop < 16'hFFFF) m_drop++;
    end
    #1;
    chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
    chk("out_data", 32'(bus.out_data), 32'(m_od));
    chk("out_ch", 32'(bus.out_ch), 32'(m_och));
    chk("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
    for (int i = 0; i < N; i++)
      chk("in_ready", 32'(bus.in_ready[i]),
          32'(mq[i].size() < cap(i)));
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++)
      bus.in_data[i*W +: W] = 8'($urandom);
  endtask

  logic [7:0] b0;
  int         d0;

  initial begin
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    model_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    for (int c = 0; c < 3; c++) tick();
    chk("idle_valid", 32'(bus.out_valid), 32'h0);
    chk("idle_ready", 32'(bus.in_ready), 32'hF);
    chk("idle_drop", 32'(bus.drop_cnt), 32'h0);

    bus.in_valid = 4'b0100;
    bus.in_data[2*W +: W] = 8'hA5;
    tick();
    bus.in_valid = '0;
    tick();
    chk("single_valid", 32'(bus.out_valid), 32'h1);
    chk("single_data", 32'(bus.out_data), 32'hA5);
    chk("single_ch", 32'(bus.out_ch), 32'h2);

    for (int c = 0; c < 20; c++) begin
      bus.in_valid = 4'hF;
      rand_data();
      tick();
    end
    bus.in_valid = '0;
    for (int c = 0; c < 12; c++) tick();

    bus.out_ready = 1'b0;
    d0 = int'(bus.drop_cnt);
    b0 = 8'h10;
    for (int c = 0; c < 6; c++) begin
      bus.in_valid = 4'b0001;
      bus.in_data[0 +: W] = 8'h10 + 8'(c);
      tick();
    end
    bus.in_valid = '0;
    chk("stall_rdy0", 32'(bus.in_ready[0]), 32'h0);
    chk("stall_drop", 32'(int'(bus.drop_cnt) - d0), 32'h1);
    chk("stall_data", 32'(bus.out_data), 32'(b0));
    tick();
    tick();
    chk("stall_hold", 32'(bus.out_data), 32'(b0));
    chk("stall_ch", 32'(bus.out_ch), 32'h0);

    for (int c = 0; c < 2; c++) begin
      bus.in_valid = 4'b0010;
      bus.in_data[W +: W] = 8'h60 + 8'(c);
      tick();
    end
    chk("skid_full", 32'(bus.in_ready[1]), 32'h0);
    bus.out_ready = 1'b1;
    bus.in_data[W +: W] = 8'h6F;
    tick();
    bus.in_valid = '0;
    chk("skid_pop_ch", 32'(bus.out_ch), 32'h1);
    chk("skid_pop_data", 32'(bus.out_data), 32'h60);
    chk("skid_cnt1", 32'(bus.in_ready[1]), 32'h1);

    for (int c = 0; c < 10; c++) begin
      bus.in_valid = 4'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rand_data();
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.in_valid = '0;
    bus.out_ready = 1'b1;
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_ready", 32'(bus.in_ready), 32'hF);
    chk("rst_drop", 32'(bus.drop_cnt), 32'h0);
    bus.in_valid = 4'b1000;
    bus.in_data[3*W +: W] = 8'h3C;
    tick();
    bus.in_valid = '0;
    tick();
    chk("rst_first_data", 32'(bus.out_data), 32'h3C);
    chk("rst_first_ch", 32'(bus.out_ch), 32'h3);

    for (int c = 0; c < 400; c++) begin
      bus.in_valid = 4'($urandom);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      rand_data();
      tick();
    end
    bus.in_valid = '0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    chk("drained", 32'(bus.out_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
